bcd_mod_counter: RTL and testbench

Parametrised two-digit BCD modulo counter. It is the generalised successor to the fixed mod-6 counter, used for clock and timer displays: seconds/minutes (mod 60), hours (mod 24), and similar. It adds parallel load with range checking, optional down-counting, and a combinational terminal-count output for same-cycle cascading. It keeps a registered carry pulse, so chained stages can use either carry style.

---
 rtl/bcd_mod_counter.sv | 73 +++++++
 tb/tb_bcd_mod_counter.sv | 112 +++++++++++
 2 files changed

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD modulo counter with range-checked load, registered co/err and combinational tc.
// Define BCD_COUNT_DOWN_EN to build the down-count path selected by dir.
module bcd_mod_counter #(
  parameter int MODULUS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       tc,
  output logic       co,
  output logic       err
);
  localparam logic [3:0] TENS_MAX = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] ONES_MAX = 4'((MODULUS - 1) % 10);
  logic [7:0] lv;
  logic       load_ok, at_max, term, nco, nerr;
  logic [3:0] nt, no;
  assign lv      = 8'(load_tens) * 8'd10 + 8'(load_ones);
  assign load_ok = load_tens <= 4'd9 && load_ones <= 4'd9 && lv <= 8'(MODULUS - 1);
  assign at_max  = tens == TENS_MAX && ones == ONES_MAX;
`ifdef BCD_COUNT_DOWN_EN
  logic at_zero;
  assign at_zero = tens == 4'd0 && ones == 4'd0;
  assign term    = dir ? at_zero : at_max;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign term       = at_max;
`endif
  assign tc = en & ~load & ~rst & term;
  always_comb begin
    nt   = tens;
    no   = ones;
    nco  = 1'b0;
    nerr = 1'b0;
    if (load) begin
      nt   = load_ok ? load_tens : 4'd0;
      no   = load_ok ? load_ones : 4'd0;
      nerr = ~load_ok;
    end else if (en) begin
      nco = term;
`ifdef BCD_COUNT_DOWN_EN
      if (dir) begin
        nt = term ? TENS_MAX : (ones == 4'd0 ? tens - 4'd1 : tens);
        no = term ? ONES_MAX : (ones == 4'd0 ? 4'd9 : ones - 4'd1);
      end else
`endif
      begin
        nt = term ? 4'd0 : (ones == 4'd9 ? tens + 4'd1 : tens);
        no = term ? 4'd0 : (ones == 4'd9 ? 4'd0 : ones + 4'd1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tens <= 4'd0;
      ones <= 4'd0;
      co   <= 1'b0;
      err  <= 1'b0;
    end else begin
      tens <= nt;
      ones <= no;
      co   <= nco;
      err  <= nerr;
    end
  end
endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb_bcd_mod_counter: checks mod-60 and mod-24 counters against an arithmetic reference model.
module tb_bcd_mod_counter;
`ifdef BCD_COUNT_DOWN_EN
  localparam bit DOWN_ON = 1'b1;
`else
  localparam bit DOWN_ON = 1'b0;
`endif
  logic clk, rst, en, dir, load;
  logic [3:0] load_tens, load_ones;
  logic [3:0] t60, o60, t24, o24;
  logic tc60, co60, er60, tc24, co24, er24;
  int v60, v24;
  int passed = 0;
  int total = 0;

  bcd_mod_counter #(.MODULUS(60)) u60 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_tens(load_tens), .load_ones(load_ones),
    .tens(t60), .ones(o60), .tc(tc60), .co(co60), .err(er60)
  );
  bcd_mod_counter #(.MODULUS(24)) u24 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_tens(load_tens), .load_ones(load_ones),
    .tens(t24), .ones(o24), .tc(tc24), .co(co24), .err(er24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic mstep(input int m, input int v, input bit r, e, l, input int lt, lo, input bit dn,
                       output int nv, output bit nco, output bit nerr);
    nv = v;
    nco = 1'b0;
    nerr = 1'b0;
    if (r) nv = 0;
    else if (l) begin
      if (lt <= 9 && lo <= 9 && 10 * lt + lo < m) nv = 10 * lt + lo;
      else begin
        nv = 0;
        nerr = 1'b1;
      end
    end else if (e) begin
      nco = dn ? (v == 0) : (v == m - 1);
      nv  = dn ? (v + m - 1) % m : (v + 1) % m;
    end
  endtask

  task automatic cyc(input bit r, e, l, input int lt, lo, input bit d);
    bit dn, c60, x60, c24, x24;
    int n60, n24;
    rst = r; en = e; load = l; dir = d;
    load_tens = 4'(lt); load_ones = 4'(lo);
    dn = DOWN_ON && d;
    #1;
    chk("tc60", {7'd0, tc60}, {7'd0, e && !l && !r && (dn ? v60 == 0 : v60 == 59)});
    chk("tc24", {7'd0, tc24}, {7'd0, e && !l && !r && (dn ? v24 == 0 : v24 == 23)});
    mstep(60, v60, r, e, l, lt, lo, dn, n60, c60, x60);
    mstep(24, v24, r, e, l, lt, lo, dn, n24, c24, x24);
    @(posedge clk); #1;
    v60 = n60;
    v24 = n24;
    chk("tens60", {4'd0, t60}, 8'(v60 / 10));
    chk("ones60", {4'd0, o60}, 8'(v60 % 10));
    chk("co60", {7'd0, co60}, {7'd0, c60});
    chk("err60", {7'd0, er60}, {7'd0, x60});
    chk("tens24", {4'd0, t24}, 8'(v24 / 10));
    chk("ones24", {4'd0, o24}, 8'(v24 % 10));
    chk("co24", {7'd0, co24}, {7'd0, c24});
    chk("err24", {7'd0, er24}, {7'd0, x24});
  endtask

  initial begin
    v60 = 0; v24 = 0;
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 2, 3, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 7, 10, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 6, 0, 0);
    cyc(0, 0, 1, 5, 9, 0);
    cyc(0, 0, 1, 10, 0, 0);
    cyc(0, 0, 1, 3, 5, 0);
    cyc(0, 1, 1, 1, 2, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 5, 9, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 1, 9, 9, 0);
    for (int i = 0; i < 400; i++) begin
      int p;
      p = int'($urandom_range(0, 99));
      cyc(p < 3, p >= 3 && ($urandom_range(0, 9) < 8), p >= 3 && p < 13,
          int'($urandom_range(0, 10)), int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
